// File: rtl/keypad_debounce_scanner_if.sv
// Keypad scanner signal bundle: row sense in, column drive and debounced key event out.
// master = scanner side, slave = keypad/consumer side.
interface keypad_debounce_scanner_if;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [3:0] key_data;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  key_row,
        output key_col,
        output key_data,
        output key_valid,
        output key_held
    );

    modport slave (
        output key_row,
        input  key_col,
        input  key_data,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_debounce_scanner.sv
// 3x4 keypad scanner with press/release debounce; emits one key_valid pulse per accepted press.
// Column drive freezes while a candidate key is debounced or held down.
module keypad_debounce_scanner #(
    parameter int unsigned COL_PERIOD = 1000,
    parameter int unsigned DEB_CYCLES = 20000
) (
    input logic                        clk,
    input logic                        rst,
    keypad_debounce_scanner_if.master  kb
);

    localparam int unsigned ColW = $clog2(COL_PERIOD);
    localparam int unsigned DebW = $clog2(DEB_CYCLES);
    localparam logic [ColW-1:0] ColLast = ColW'(COL_PERIOD - 1);
    localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        StScan     = 2'd0,
        StDebounce = 2'd1,
        StHeld     = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      row_meta_q, row_s_q;
    logic [ColW-1:0] col_cnt_q, col_cnt_d;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic [2:0]      key_col_q, key_col_d;
    logic [3:0]      cand_code_q, cand_code_d;
    logic [3:0]      cand_row_q, cand_row_d;
    logic [3:0]      key_data_q, key_data_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;

    function automatic logic [2:0] rotate_col(input logic [2:0] col);
        case (col)
            3'b001:  return 3'b010;
            3'b010:  return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] row);
        case (row)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] col_index(input logic [2:0] col);
        case (col)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    logic       row_onehot;
    logic [3:0] scan_code;

    always_comb begin
        row_onehot = (row_s_q == 4'b0001) || (row_s_q == 4'b0010) ||
                     (row_s_q == 4'b0100) || (row_s_q == 4'b1000);
        // code = 3*row + col + 1, giving 1..12
        scan_code  = ({2'b00, row_index(row_s_q)} * 4'd3) + {2'b00, col_index(key_col_q)} + 4'd1;
    end

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        key_col_d   = key_col_q;
        cand_code_d = cand_code_q;
        cand_row_d  = cand_row_q;
        key_data_d  = key_data_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            StScan: begin
                if (col_cnt_q == ColLast) begin
                    col_cnt_d = '0;
                    if (row_onehot) begin
                        cand_code_d = scan_code;
                        cand_row_d  = row_s_q;
                        deb_cnt_d   = '0;
                        state_d     = StDebounce;
                    end else begin
                        key_col_d = rotate_col(key_col_q);
                    end
                end else begin
                    col_cnt_d = col_cnt_q + ColW'(1);
                end
            end

            StDebounce: begin
                if (row_s_q == cand_row_q) begin
                    if (deb_cnt_q == DebLast) begin
                        deb_cnt_d   = '0;
                        key_data_d  = cand_code_q;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = StHeld;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DebW'(1);
                    end
                end else begin
                    deb_cnt_d = '0;
                    col_cnt_d = '0;
                    key_col_d = rotate_col(key_col_q);
                    state_d   = StScan;
                end
            end

            StHeld: begin
                // Release needs an unbroken run of all-zero rows; any activity restarts it.
                if (row_s_q == 4'b0000) begin
                    if (deb_cnt_q == DebLast) begin
                        deb_cnt_d  = '0;
                        col_cnt_d  = '0;
                        key_data_d = 4'd0;
                        key_held_d = 1'b0;
                        key_col_d  = rotate_col(key_col_q);
                        state_d    = StScan;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DebW'(1);
                    end
                end else begin
                    deb_cnt_d = '0;
                end
            end

            default: begin
                state_d    = StScan;
                col_cnt_d  = '0;
                deb_cnt_d  = '0;
                key_col_d  = 3'b001;
                key_data_d = 4'd0;
                key_held_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q  <= 4'd0;
            row_s_q     <= 4'd0;
            state_q     <= StScan;
            col_cnt_q   <= '0;
            deb_cnt_q   <= '0;
            key_col_q   <= 3'b001;
            cand_code_q <= 4'd0;
            cand_row_q  <= 4'd0;
            key_data_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= kb.key_row;
            row_s_q     <= row_meta_q;
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            key_col_q   <= key_col_d;
            cand_code_q <= cand_code_d;
            cand_row_q  <= cand_row_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kb.key_col   = key_col_q;
    assign kb.key_data  = key_data_q;
    assign kb.key_valid = key_valid_q;
    assign kb.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_debounce_scanner.sv
// Bench for keypad_debounce_scanner: a keypad model turns pressed keys into row lines for the
// currently driven column; a vector table covers per-key presses, hand sequences the corners.
module tb_keypad_debounce_scanner;

    localparam int unsigned ColPeriod = 4;
    localparam int unsigned DebCycles = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_debounce_scanner_if kif ();

    logic [12:1] pressed;
    logic [3:0]  row_drive;

    // Physical keypad: a row reads high when a pressed key sits in the driven column.
    always_comb begin
        row_drive = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[3 * r + c + 1] && kif.key_col[c]) row_drive[r] = 1'b1;
            end
        end
    end
    assign kif.key_row = row_drive;

    keypad_debounce_scanner #(
        .COL_PERIOD (ColPeriod),
        .DEB_CYCLES (DebCycles)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kb  (kif.master)
    );

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    logic [3:0] last_code = 4'd0;

    typedef struct {
        logic [12:1] keys;
        int          exp_pulses;
        logic [3:0]  exp_code;
        string       name;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [12:1] km(input int k);
        logic [12:1] m;
        m    = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (kif.key_valid) begin
            pulses++;
            last_code = kif.key_data;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_col"},   32'(kif.key_col),   32'(3'b001));
        check({name, "_data"},  32'(kif.key_data),  32'd0);
        check({name, "_valid"}, 32'(kif.key_valid), 32'd0);
        check({name, "_held"},  32'(kif.key_held),  32'd0);
    endtask

    // Waits (bounded) until the column stays put longer than a scan dwell, i.e. DEBOUNCE.
    task automatic wait_frozen(input logic [2:0] col, output bit found);
        int run;
        run   = 0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (kif.key_col == col) run++;
            else run = 0;
            if (run >= 6) found = 1'b1;
        end
    endtask

    logic [2:0] col_seq [3];
    bit         found;
    bit         rotated;

    initial begin
        vecs[0] = '{km(1),          1, 4'd1,  "key_1"};
        vecs[1] = '{km(3),          1, 4'd3,  "key_3"};
        vecs[2] = '{km(5),          1, 4'd5,  "key_5"};
        vecs[3] = '{km(9),          1, 4'd9,  "key_9"};
        vecs[4] = '{km(10),         1, 4'd10, "key_star"};
        vecs[5] = '{km(11),         1, 4'd11, "key_0"};
        vecs[6] = '{km(12),         1, 4'd12, "key_hash"};
        vecs[7] = '{km(10) | km(1), 0, 4'd0,  "two_rows_col0"};
        col_seq[0] = 3'b001;
        col_seq[1] = 3'b010;
        col_seq[2] = 3'b100;

        // Reset and idle rotation
        pressed = '0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst    = 1'b0;
        pulses = 0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            check("idle_col", 32'(kif.key_col), 32'(col_seq[(k / 4) % 3]));
            check("idle_data", 32'(kif.key_data), 32'd0);
        end
        check("idle_no_valid", 32'(pulses), 32'd0);

        // Exact latency of a '5' press started at the top of column 001's dwell
        pressed[5] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check("k5_valid", 32'(kif.key_valid), 32'(e == 16));
            if (e == 16) check("k5_data", 32'(kif.key_data), 32'd5);
            if (e == 17) check("k5_held", 32'(kif.key_held), 32'd1);
        end
        pressed[5] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("k5_release_data", 32'(kif.key_data), (e < 10) ? 32'd5 : 32'd0);
            check("k5_release_held", 32'(kif.key_held), (e < 10) ? 32'd1 : 32'd0);
        end
        ticks(5);

        // Table of single presses and a same-column double press
        for (int v = 0; v < 8; v++) begin
            pulses    = 0;
            last_code = 4'd0;
            pressed   = vecs[v].keys;
            ticks(80);
            check({vecs[v].name, "_hold_data"}, 32'(kif.key_data), 32'(vecs[v].exp_code));
            check({vecs[v].name, "_hold_held"}, 32'(kif.key_held), 32'(vecs[v].exp_pulses != 0));
            pressed = '0;
            ticks(30);
            check({vecs[v].name, "_pulses"}, 32'(pulses), 32'(vecs[v].exp_pulses));
            check({vecs[v].name, "_code"}, 32'(last_code), 32'(vecs[v].exp_code));
            check({vecs[v].name, "_released"}, 32'(kif.key_data), 32'd0);
        end

        // Bouncing contact on '8' settles to exactly one event
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            pressed[8] = ~pressed[8];
            tick();
        end
        pressed[8] = 1'b1;
        ticks(60);
        check("bounce_pulses", 32'(pulses), 32'd1);
        check("bounce_code", 32'(last_code), 32'd8);
        pressed = '0;
        ticks(20);
        check("bounce_released", 32'(kif.key_data), 32'd0);

        // Press shorter than the debounce window
        pulses     = 0;
        pressed[5] = 1'b1;
        wait_frozen(3'b010, found);
        check("short_reached_debounce", 32'(found), 32'd1);
        pressed = '0;
        rotated = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (kif.key_col != 3'b010) rotated = 1'b1;
        end
        check("short_no_valid", 32'(pulses), 32'd0);
        check("short_rotation_resumed", 32'(rotated), 32'd1);
        check("short_data", 32'(kif.key_data), 32'd0);

        // Second key while '9' is held
        pulses     = 0;
        pressed[9] = 1'b1;
        ticks(60);
        check("held9_pulses", 32'(pulses), 32'd1);
        check("held9_code", 32'(last_code), 32'd9);
        pulses     = 0;
        pressed[6] = 1'b1;
        pressed[7] = 1'b1;
        ticks(40);
        check("held9_second_no_pulse", 32'(pulses), 32'd0);
        check("held9_data_kept", 32'(kif.key_data), 32'd9);
        check("held9_still_held", 32'(kif.key_held), 32'd1);
        pressed[6] = 1'b0;
        pressed[7] = 1'b0;
        ticks(5);
        check("held9_after_second", 32'(kif.key_data), 32'd9);
        pressed[9] = 1'b0;
        ticks(15);
        check("held9_released", 32'(kif.key_data), 32'd0);
        check("held9_no_late_pulse", 32'(pulses), 32'd0);

        // Reset during DEBOUNCE, then a fresh event
        pressed[5] = 1'b1;
        wait_frozen(3'b010, found);
        check("rst_deb_reached", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_idle("rst_deb");
        tick();
        rst    = 1'b0;
        pulses = 0;
        ticks(60);
        check("rst_deb_fresh_pulses", 32'(pulses), 32'd1);
        check("rst_deb_fresh_code", 32'(last_code), 32'd5);

        // Reset during HELD, then a fresh event
        check("rst_held_in_held", 32'(kif.key_held), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_idle("rst_held");
        tick();
        rst    = 1'b0;
        pulses = 0;
        ticks(60);
        check("rst_held_fresh_pulses", 32'(pulses), 32'd1);
        check("rst_held_fresh_code", 32'(last_code), 32'd5);
        pressed = '0;
        ticks(20);
        check("final_released", 32'(kif.key_data), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
